// File: rtl/pe_seq_ctrl.sv
// Frame sequencer for a background-removal PE: averages a frame from pixel
// memory, then streams each pixel through the PE and writes back its result.
module pe_seq_ctrl #(
   parameter int unsigned LOG2_NPIX = 4
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_start,
   input  logic [7:0]           i_threshold,
   input  logic [7:0]           i_desired_bg_r,
   input  logic [7:0]           i_desired_bg_g,
   input  logic [7:0]           i_desired_bg_b,
   output logic                 o_mem_rd,
   output logic [LOG2_NPIX-1:0] o_mem_addr,
   input  logic [7:0]           i_mem_r,
   input  logic [7:0]           i_mem_g,
   input  logic [7:0]           i_mem_b,
   output logic [7:0]           o_red_in,
   output logic [7:0]           o_green_in,
   output logic [7:0]           o_blue_in,
   output logic [7:0]           o_red_exp,
   output logic [7:0]           o_green_exp,
   output logic [7:0]           o_blue_exp,
   output logic [7:0]           o_pe_threshold,
   output logic [7:0]           o_pe_bg_r,
   output logic [7:0]           o_pe_bg_g,
   output logic [7:0]           o_pe_bg_b,
   output logic                 o_start_bgremoval,
   input  logic                 i_pe_done,
   input  logic [7:0]           i_red_out,
   input  logic [7:0]           i_green_out,
   input  logic [7:0]           i_blue_out,
   output logic                 o_ack,
   output logic                 o_wr_en,
   output logic [LOG2_NPIX-1:0] o_wr_addr,
   output logic [7:0]           o_wr_r,
   output logic [7:0]           o_wr_g,
   output logic [7:0]           o_wr_b,
   output logic                 o_busy,
   output logic                 o_done
);

   localparam int unsigned SUM_W = 8 + LOG2_NPIX;
   localparam logic [LOG2_NPIX-1:0] IDX_LAST = {LOG2_NPIX{1'b1}};

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_SUM_RD   = 4'd1,
      S_SUM_ACC  = 4'd2,
      S_AVG      = 4'd3,
      S_BG_RD    = 4'd4,
      S_BG_LOAD  = 4'd5,
      S_BG_ISSUE = 4'd6,
      S_BG_WAIT  = 4'd7,
      S_BG_ACK   = 4'd8,
      S_FIN      = 4'd9
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [LOG2_NPIX-1:0]   r_idx;
   logic [LOG2_NPIX-1:0]   w_idx_nxt;
   logic [SUM_W-1:0]       r_sum_r;
   logic [SUM_W-1:0]       r_sum_g;
   logic [SUM_W-1:0]       r_sum_b;

   logic w_accept;
   logic w_sum_add;
   logic w_avg_ld;
   logic w_pix_ld;
   logic w_res_ld;
   logic w_mem_rd_nxt;
   logic w_start_pe_nxt;
   logic w_ack_nxt;
   logic w_busy_nxt;
   logic w_done_nxt;

   // State register
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state, datapath enables, and next values of the strobe outputs
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_accept    = 1'b0;
      w_sum_add   = 1'b0;
      w_avg_ld    = 1'b0;
      w_pix_ld    = 1'b0;
      w_res_ld    = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_accept    = 1'b1;
               w_idx_nxt   = '0;
               w_state_nxt = S_SUM_RD;
            end
         end
         S_SUM_RD:   w_state_nxt = S_SUM_ACC;
         S_SUM_ACC: begin
            w_sum_add = 1'b1;
            if (r_idx == IDX_LAST) begin
               w_idx_nxt   = '0;
               w_state_nxt = S_AVG;
            end else begin
               w_idx_nxt   = r_idx + LOG2_NPIX'(1);
               w_state_nxt = S_SUM_RD;
            end
         end
         S_AVG: begin
            w_avg_ld    = 1'b1;
            w_state_nxt = S_BG_RD;
         end
         S_BG_RD:    w_state_nxt = S_BG_LOAD;
         S_BG_LOAD: begin
            w_pix_ld    = 1'b1;
            w_state_nxt = S_BG_ISSUE;
         end
         S_BG_ISSUE: w_state_nxt = S_BG_WAIT;
         S_BG_WAIT: begin
            if (i_pe_done) begin
               w_res_ld    = 1'b1;
               w_state_nxt = S_BG_ACK;
            end
         end
         // Ack is held for the whole stay here, so it lasts at least one cycle
         S_BG_ACK: begin
            if (!i_pe_done) begin
               if (r_idx == IDX_LAST) begin
                  w_idx_nxt   = '0;
                  w_state_nxt = S_FIN;
               end else begin
                  w_idx_nxt   = r_idx + LOG2_NPIX'(1);
                  w_state_nxt = S_BG_RD;
               end
            end
         end
         S_FIN:      w_state_nxt = S_IDLE;
         default:    w_state_nxt = S_IDLE;
      endcase

      w_mem_rd_nxt   = (w_state_nxt == S_SUM_RD) || (w_state_nxt == S_BG_RD);
      w_start_pe_nxt = (w_state_nxt == S_BG_ISSUE);
      w_ack_nxt      = (w_state_nxt == S_BG_ACK);
      w_busy_nxt     = (w_state_nxt != S_IDLE);
      w_done_nxt     = (w_state_nxt == S_FIN);
   end

   // Datapath and registered outputs
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_idx             <= '0;
         r_sum_r           <= '0;
         r_sum_g           <= '0;
         r_sum_b           <= '0;
         o_pe_threshold    <= '0;
         o_pe_bg_r         <= '0;
         o_pe_bg_g         <= '0;
         o_pe_bg_b         <= '0;
         o_red_exp         <= '0;
         o_green_exp       <= '0;
         o_blue_exp        <= '0;
         o_red_in          <= '0;
         o_green_in        <= '0;
         o_blue_in         <= '0;
         o_wr_r            <= '0;
         o_wr_g            <= '0;
         o_wr_b            <= '0;
         o_wr_addr         <= '0;
         o_wr_en           <= 1'b0;
         o_mem_rd          <= 1'b0;
         o_mem_addr        <= '0;
         o_start_bgremoval <= 1'b0;
         o_ack             <= 1'b0;
         o_busy            <= 1'b0;
         o_done            <= 1'b0;
      end else begin
         r_idx <= w_idx_nxt;

         if (w_accept) begin
            o_pe_threshold <= i_threshold;
            o_pe_bg_r      <= i_desired_bg_r;
            o_pe_bg_g      <= i_desired_bg_g;
            o_pe_bg_b      <= i_desired_bg_b;
            r_sum_r        <= '0;
            r_sum_g        <= '0;
            r_sum_b        <= '0;
         end else if (w_sum_add) begin
            r_sum_r <= r_sum_r + SUM_W'(i_mem_r);
            r_sum_g <= r_sum_g + SUM_W'(i_mem_g);
            r_sum_b <= r_sum_b + SUM_W'(i_mem_b);
         end

         // Floor average; held until the next frame reaches AVG
         if (w_avg_ld) begin
            o_red_exp   <= 8'(r_sum_r >> LOG2_NPIX);
            o_green_exp <= 8'(r_sum_g >> LOG2_NPIX);
            o_blue_exp  <= 8'(r_sum_b >> LOG2_NPIX);
         end

         if (w_pix_ld) begin
            o_red_in   <= i_mem_r;
            o_green_in <= i_mem_g;
            o_blue_in  <= i_mem_b;
         end

         if (w_res_ld) begin
            o_wr_r    <= i_red_out;
            o_wr_g    <= i_green_out;
            o_wr_b    <= i_blue_out;
            o_wr_addr <= r_idx;
         end

         o_wr_en           <= w_res_ld;
         o_mem_rd          <= w_mem_rd_nxt;
         o_mem_addr        <= w_idx_nxt;
         o_start_bgremoval <= w_start_pe_nxt;
         o_ack             <= w_ack_nxt;
         o_busy            <= w_busy_nxt;
         o_done            <= w_done_nxt;
      end
   end

endmodule

// File: doc/pe_seq_ctrl.md
PE_SEQ_CTRL -- requirements
Module: pe_seq_ctrl

Interface
REQ-001 Parameter LOG2_NPIX, default 4, log2 of pixel count per frame (NPIX = 2**LOG2_NPIX, range 1..10).
REQ-002 Clk  in  1  single clock; all state updates on rising edge.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 Start  in  1  frame start request; honoured only in IDLE.
REQ-005 threshold, desired_bg_r, desired_bg_g, desired_bg_b  in  8 each  config; sampled on the Start-accept edge.
REQ-006 mem_rd  out  1  pixel memory read strobe; mem_addr  out  LOG2_NPIX  read address.
REQ-007 mem_r, mem_g, mem_b  in  8 each  read data, valid exactly one cycle after mem_rd.
REQ-008 red_in, green_in, blue_in  out  8 each  pixel presented to PE.
REQ-009 red_exp, green_exp, blue_exp  out  8 each  frame-average colour presented to PE.
REQ-010 pe_threshold, pe_bg_r, pe_bg_g, pe_bg_b  out  8 each  registered copies of sampled config.
REQ-011 Start_BgRemoval  out  1  one-cycle PE start pulse.
REQ-012 pe_done  in  1  PE result valid (level); red_out, green_out, blue_out  in  8 each  PE result.
REQ-013 Ack  out  1  four-phase acknowledge to PE.
REQ-014 wr_en  out  1; wr_addr  out  LOG2_NPIX; wr_r, wr_g, wr_b  out  8 each  result write port.
REQ-015 busy  out  1  high in every state except IDLE; done  out  1  one-cycle end-of-frame pulse.

Function
REQ-016 States SHALL be IDLE, SUM_RD, SUM_ACC, AVG, BG_RD, BG_LOAD, BG_ISSUE, BG_WAIT, BG_ACK, FIN.
REQ-017 IDLE: Start=1 -> latch config, clear idx and R/G/B sums, go SUM_RD; Start ignored in any other state.
REQ-018 SUM_RD: mem_rd=1, mem_addr=idx; next SUM_ACC.
REQ-019 SUM_ACC: add mem_r/g/b to 8+LOG2_NPIX-bit sums (no overflow possible); idx==NPIX-1 -> clear idx, AVG; else idx+1, SUM_RD.
REQ-020 AVG: *_exp = sum >> LOG2_NPIX (floor), held until next frame's AVG; next BG_RD.
REQ-021 BG_RD: mem_rd=1, mem_addr=idx; next BG_LOAD.
REQ-022 BG_LOAD: register mem data onto red_in/green_in/blue_in; next BG_ISSUE.
REQ-023 BG_ISSUE: Start_BgRemoval=1 for exactly this cycle; next BG_WAIT.
REQ-024 BG_WAIT: remain until pe_done=1 (no timeout); on that edge capture red/green/blue_out into wr_r/g/b, wr_addr=idx, wr_en=1 for the following single cycle; go BG_ACK.
REQ-025 BG_ACK: Ack=1 while pe_done=1; on pe_done=0 drop Ack; idx==NPIX-1 -> FIN, else idx+1, BG_RD.
REQ-026 If pe_done is already low on BG_ACK entry, Ack SHALL still be high for exactly one cycle.
REQ-027 FIN: done=1 for one cycle; next IDLE; a Start in FIN is ignored.
REQ-028 Latency per frame with zero-wait PE (done one cycle after start, dropped one cycle after Ack): 2*NPIX + 1 + 6*NPIX + 1 cycles, Start-accept to done.
REQ-029 mem_rd, Start_BgRemoval, wr_en, done SHALL be zero outside the states named above.

Reset
REQ-030 Reset=1 in any state, including mid-frame, SHALL on the next edge force IDLE and zero every output, idx, sums, and latched config.
REQ-031 Reset SHALL take priority over Start and pe_done in the same cycle.
REQ-032 After a mid-frame reset, a stale pe_done=1 SHALL be ignored until a new frame reaches BG_WAIT.

Verification
REQ-033 NPIX=16, all pixels (61,133,198), threshold 30, bg (10,10,10), stub PE -> exp=(61,133,198); 16 writes addr 0..15, each equal to stub output; one done pulse.
REQ-034 Red pixels 0..15, G/B=255 -> red_exp=7 (sum 120, floored), green_exp=blue_exp=255 (sum 4080, no wrap).
REQ-035 Stub PE delays pe_done 5 cycles and holds it 3 cycles after Ack -> no write until pe_done, exactly one wr_en per pixel, Ack high until pe_done falls.
REQ-036 Start pulsed during SUM_ACC and during FIN -> no restart; frame completes with 16 writes; config unchanged.
REQ-037 Reset asserted during BG_WAIT at idx=5 -> next cycle IDLE, all outputs 0, busy=0; new Start runs a full frame of 16 writes from addr 0.
REQ-038 Start and Reset in the same cycle -> IDLE, busy stays 0.
